// File: rtl/key_pulse_gen_pkg.sv
// Shared types and constants for the push-button / slide-switch conditioning front end.
package key_pulse_gen_pkg;

    typedef enum logic [1:0] {
        REL       = 2'd0,
        PRESS_CHK = 2'd1,
        PRS       = 2'd2,
        REL_CHK   = 2'd3
    } key_state_e;

    localparam int KEY_REC     = 0;
    localparam int KEY_PLAY    = 1;
    localparam int KEY_STOP    = 2;
    localparam int SW_SLOW_BIT = 4;

endpackage

// File: rtl/key_pulse_gen_debounce.sv
// Single push-button conditioner: 2-flop sync, inversion to pressed=1, debounce FSM.
//
// state     | meaning
// REL       | debounced released, level 0
// PRESS_CHK | synced pressed, counting toward accepting the press
// PRS       | debounced pressed, level 1
// REL_CHK   | synced released, counting toward accepting the release
module key_pulse_gen_debounce
    import key_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic key_n,
    output logic level,
    output logic press_req
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // Sync chain holds the inverted key so that reset reads as released.
    logic [1:0]       sync_q;
    logic             pressed;
    key_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign pressed = sync_q[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            state  <= REL;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], ~key_n};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_req = 1'b0;
        case (state)
            REL: begin
                if (pressed) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRS;
                    cnt_nxt   = '0;
                    press_req = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRS: begin
                if (!pressed) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = '0;
                end
            end
            REL_CHK: begin
                if (pressed) begin
                    state_nxt = PRS;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = REL;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level = (state == PRS) || (state == REL_CHK);

endmodule

// File: rtl/key_pulse_gen.sv
// Conditions raw buttons into one-hot single-cycle press pulses and raw switches into
// debounced levels with a change strobe.
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int N_KEYS       = KEY_STOP + 1,
    parameter int N_SW         = SW_SLOW_BIT + 1,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key_n,
    input  logic [N_SW-1:0]   i_sw,
    output logic [N_KEYS-1:0] o_key_pulse,
    output logic [N_KEYS-1:0] o_key_level,
    output logic [3:0]        o_speed,
    output logic              o_slow,
    output logic              o_sw_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [N_KEYS-1:0] press_req;
    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] cand;
    logic [N_KEYS-1:0] grant;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_pulse_gen_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .key_n    (i_key_n[k]),
            .level    (o_key_level[k]),
            .press_req(press_req[k])
        );
    end

    // Fresh requests join the pending set in the same cycle, so an uncontended
    // press reaches o_key_pulse together with its level.
    always_comb begin
        cand  = pending | press_req;
        grant = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (cand[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending     <= '0;
            o_key_pulse <= '0;
        end else begin
            pending     <= cand & ~grant;
            o_key_pulse <= grant;
        end
    end

    logic [N_SW-1:0]  sw_s1, sw_s2, sw_prev, sw_deb;
    logic [CNT_W-1:0] sw_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_s1        <= '0;
            sw_s2        <= '0;
            sw_prev      <= '0;
            sw_deb       <= '0;
            sw_cnt       <= '0;
            o_sw_changed <= 1'b0;
        end else begin
            sw_s1        <= i_sw;
            sw_s2        <= sw_s1;
            sw_prev      <= sw_s2;
            o_sw_changed <= 1'b0;
            if (sw_s2 != sw_prev) begin
                sw_cnt <= '0;
            end else if (sw_s2 != sw_deb) begin
                if (sw_cnt == CNT_LAST) begin
                    sw_deb       <= sw_s2;
                    sw_cnt       <= '0;
                    o_sw_changed <= 1'b1;
                end else begin
                    sw_cnt <= sw_cnt + CNT_W'(1);
                end
            end else begin
                sw_cnt <= '0;
            end
        end
    end

    assign o_speed = sw_deb[3:0];
    assign o_slow  = sw_deb[SW_SLOW_BIT];

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with DEBOUNCE_CYC=4 (6-cycle press latency).
module tb_key_pulse_gen;
    import key_pulse_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] key_n;
    logic [4:0] sw;
    logic [2:0] pulse;
    logic [2:0] level;
    logic [3:0] speed;
    logic       slow;
    logic       chg;

    key_pulse_gen #(
        .N_KEYS      (3),
        .N_SW        (5),
        .DEBOUNCE_CYC(4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_n     (key_n),
        .i_sw        (sw),
        .o_key_pulse (pulse),
        .o_key_level (level),
        .o_speed     (speed),
        .o_slow      (slow),
        .o_sw_changed(chg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int         cyc, first_off, npulse, multi, chg_cnt, chg_off;
    logic [2:0] first_val;
    logic [2:0] lvl_or;
    logic [2:0] seq[$];
    logic [2:0] lvl_q[$];
    logic [8:0] s3;
    int         bounce_lo[3] = '{1, 2, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc       = 0;
        first_off = -1;
        npulse    = 0;
        multi     = 0;
        chg_cnt   = 0;
        chg_off   = -1;
        first_val = '0;
        lvl_or    = '0;
        seq.delete();
        lvl_q.delete();
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pulse != 3'b000) begin
                if (first_off < 0) begin
                    first_off = cyc;
                    first_val = pulse;
                end
                npulse++;
                seq.push_back(pulse);
                if ($countones(pulse) > 1) multi++;
            end
            if (chg) begin
                chg_cnt++;
                if (chg_off < 0) chg_off = cyc;
            end
            lvl_q.push_back(level);
            lvl_or = lvl_or | level;
            cyc++;
        end
    endtask

    function automatic logic [8:0] pack_seq();
        logic [8:0] r = '0;
        for (int i = 0; i < seq.size() && i < 3; i++) r[i*3 +: 3] = seq[i];
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        key_n = 3'b111;
        sw    = 5'b0;
        clr();
        watch(3);
        chk("reset_outs", {pulse, level, speed, slow, chg}, 32'h0);
        rst_n = 1'b1;
        clr();
        watch(6);
        chk("idle_no_pulse", npulse, 0);

        // Clean press of key 1, held 20 cycles, then released
        clr();
        key_n[KEY_PLAY] = 1'b0;
        watch(20);
        chk("k1_pulse_cnt", npulse, 1);
        chk("k1_pulse_val", first_val, 3'b010);
        chk("k1_pulse_lat", first_off, 6);
        chk("k1_lvl_before", lvl_q[5][KEY_PLAY], 1'b0);
        chk("k1_lvl_at", lvl_q[6][KEY_PLAY], 1'b1);
        chk("k1_lvl_held", lvl_q[19][KEY_PLAY], 1'b1);
        clr();
        key_n[KEY_PLAY] = 1'b1;
        watch(12);
        chk("k1_rel_no_pulse", npulse, 0);
        chk("k1_rel_lvl5", lvl_q[5][KEY_PLAY], 1'b1);
        chk("k1_rel_lvl6", lvl_q[6][KEY_PLAY], 1'b0);

        // Key 0 bounce: 1-, 2-, 3-cycle lows separated by highs
        clr();
        foreach (bounce_lo[i]) begin
            key_n[KEY_REC] = 1'b0;
            watch(bounce_lo[i]);
            key_n[KEY_REC] = 1'b1;
            watch(2);
        end
        chk("bounce_no_pulse", npulse, 0);
        chk("bounce_no_level", lvl_or, 3'b000);
        clr();
        key_n[KEY_REC] = 1'b0;
        watch(12);
        chk("bounce_pulse_cnt", npulse, 1);
        chk("bounce_pulse_val", first_val, 3'b001);
        chk("bounce_pulse_lat", first_off, 6);
        clr();
        key_n[KEY_REC] = 1'b1;
        watch(12);
        chk("k0_rel_no_pulse", npulse, 0);

        // Three keys pressed on the same raw cycle
        clr();
        key_n = 3'b000;
        watch(15);
        chk("tri_pulse_cnt", npulse, 3);
        chk("tri_order", pack_seq(), 9'b100_010_001);
        chk("tri_first_lat", first_off, 6);
        chk("tri_onehot", multi, 0);
        chk("tri_levels", lvl_q[14], 3'b111);
        key_n = 3'b111;
        watch(12);

        // Switch glitch then stable 1_0011
        clr();
        sw = 5'b1_0011;
        watch(3);
        sw = 5'b0;
        watch(2);
        chk("sw_glitch_chg", chg_cnt, 0);
        chk("sw_glitch_val", {slow, speed}, 5'b0);
        clr();
        sw = 5'b1_0011;
        watch(12);
        chk("sw_chg_cnt", chg_cnt, 1);
        chk("sw_chg_lat", chg_off, 6);
        chk("sw_speed", speed, 4'h3);
        chk("sw_slow", slow, 1'b1);

        // Key 2 held, reset mid PRESS_CHK
        clr();
        key_n[KEY_STOP] = 1'b0;
        watch(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {pulse, level, speed, slow, chg}, 32'h0);
        clr();
        watch(3);
        chk("midrst_no_pulse", npulse, 0);
        chk("midrst_no_level", lvl_or, 3'b000);
        chk("midrst_sw_zero", {slow, speed, chg}, 6'b0);
        rst_n = 1'b1;
        clr();
        watch(15);
        chk("postrst_pulse_cnt", npulse, 1);
        chk("postrst_pulse_val", first_val, 3'b100);
        chk("postrst_pulse_lat", (first_off >= 5) && (first_off <= 7), 1'b1);
        clr();
        key_n[KEY_STOP] = 1'b1;
        watch(12);
        chk("postrst_rel_no_pulse", npulse, 0);
        chk("postrst_rel_level", level, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
- Front-end conditioning stage that feeds the recorder/player control FSM.
- Turns raw board push-buttons (active-low) into clean single-cycle, active-high press pulses (key_0 record/pause, key_1 play/pause, key_2 stop).
- Turns raw speed/slow slide switches into debounced, stable levels.
- Guarantees at most one key pulse per i_clk cycle, so the downstream FSM never sees two commands in the same cycle.

Parameters:
- N_KEYS, 3, number of push-buttons.
- N_SW, 5, number of slide switches; bits [3:0] are speed, bit [4] is slow.
- DEBOUNCE_CYC, 500000, consecutive stable i_clk cycles required before a level is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYC), debounce counter width (derived).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_key_n  input  N_KEYS  raw push-buttons, active-low, asynchronous.
- i_sw  input  N_SW  raw slide switches, asynchronous.
- o_key_pulse  output  N_KEYS  one-cycle press pulse per key, one-hot or zero.
- o_key_level  output  N_KEYS  debounced pressed level (1 = held).
- o_speed  output  4  debounced i_sw[3:0].
- o_slow  output  1  debounced i_sw[4].
- o_sw_changed  output  1  one-cycle pulse when o_speed/o_slow take a new value.

Behaviour:
- **Reset:** all outputs 0, all counters 0, all pending bits 0. Every key is treated as released. The debounced switch vector is 0.
- **Synchronisation:** every raw input passes through a 2-flop synchronizer. Key inputs are inverted after sync, so pressed = 1.
- **Per-key debounce FSM, four states:**
  - REL: debounced level 0.
  - PRESS_CHK: counting toward pressed.
  - PRS: debounced level 1.
  - REL_CHK: counting toward released.
- **Key FSM transitions:**
  - REL -> PRESS_CHK when synced = 1; counter cleared.
  - PRESS_CHK: if synced = 0, return to REL. Else increment the counter. At DEBOUNCE_CYC-1, go to PRS and raise that key's press request.
  - PRS -> REL_CHK when synced = 0.
  - REL_CHK: if synced = 1, return to PRS. At DEBOUNCE_CYC-1, go to REL. No pulse is generated on release.
- **Key latency:** a clean raw falling edge sampled at cycle t gives o_key_level = 1 and the request at cycle t+2+DEBOUNCE_CYC.
- **Bounce:** any glitch shorter than DEBOUNCE_CYC cycles produces no level change and no pulse.
- **Pulse arbiter:**
  - Each key has a pending bit, set by its press request.
  - Each cycle, the lowest-index pending key is emitted on o_key_pulse (registered, exactly 1 cycle) and its pending bit is cleared.
  - Other pending keys are deferred, not dropped. With three simultaneous requests, pulses go out on three consecutive cycles in order 0, 1, 2.
  - A new request for a key that is already pending is merged, giving one pulse.
- **Held key:** one pulse per press; no auto-repeat. A key held through reset deassertion produces one pulse after debounce.
- **Switches:**
  - One shared CNT_W counter compares the synced vector with the debounced vector.
  - While they differ and the synced vector is unchanged from the previous cycle, the counter increments. Any change in the synced vector clears it.
  - After DEBOUNCE_CYC stable differing cycles, the debounced vector loads the synced value, the counter clears, and o_sw_changed pulses in the same cycle as the new o_speed/o_slow.
  - If the synced vector returns to the debounced value before then, the counter clears and there is no update.
- **Counter overflow:** counters saturate/clear as above and never wrap.
- **Reset mid-count:** all state is discarded; no pulse is emitted after reset for a press that was interrupted.

Decomposition:
- Shared package (key_pkg): enum for the key FSM states {REL, PRESS_CHK, PRS, REL_CHK}; localparams for key indices KEY_REC=0, KEY_PLAY=1, KEY_STOP=2; SW_SLOW_BIT=4.
- Natural sub-module: key_debounce, a single-key 2-flop sync plus FSM plus counter with outputs level and press request. It is instantiated N_KEYS times via generate.
- The arbiter and switch debounce stay in the top of this block.

Test Plan (bench uses DEBOUNCE_CYC=4):
- Clean press of key 1, held 20 cycles, then released -> o_key_pulse = 3'b010 for exactly 1 cycle, 6 cycles after the raw edge; o_key_level[1] high from then until 6 cycles after release; no pulse on release.
- Key 0 bounces with 1-, 2- and 3-cycle low glitches separated by highs, then stays low -> exactly one pulse 3'b001, 6 cycles after the final stable low edge.
- Keys 0, 1 and 2 pressed on the same raw cycle -> pulses 3'b001, 3'b010, 3'b100 on three consecutive cycles; never more than one bit set.
- Switch vector goes 0 -> 5'b1_0011 with a 2-cycle return to 0 in the middle -> no update during the glitch. After 4 stable cycles: o_speed = 4'h3, o_slow = 1, and o_sw_changed pulses once.
- Key 2 held and i_rst_n asserted mid-PRESS_CHK for 3 cycles, then released with the key still held -> all outputs 0 during reset; one pulse 3'b100 about 6 cycles after reset release; no pulse when the key is later released.
